// File: rtl/stream_pkt_generator_pkg.sv
// Shared definitions for the stream packet generator.
//   BYTES_PER_FLIT : bytes carried by one full flit
//   FILL_BYTE      : constant byte used to pad the payload below the header
//   gen_state_t    : generator FSM state encoding
package stream_pkt_generator_pkg;

   localparam int unsigned BYTES_PER_FLIT = 64;
   localparam logic [7:0]  FILL_BYTE      = 8'h5A;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP,
      ST_DONE
   } gen_state_t;

endpackage

// File: rtl/stream_pkt_generator_len_calc.sv
// Packet geometry from a byte length: effective length (0 means one full
// flit), flit count = ceil(len / bytes-per-flit), and unused bytes in the
// final flit.
//   len_i     : requested packet length in bytes
//   eff_len_o : effective length (len_i, or BYTES_PER_FLIT when len_i is 0)
//   flits_o   : number of flits in the packet
//   empty_o   : unused bytes in the eop flit
module stream_pkt_generator_len_calc
   import stream_pkt_generator_pkg::*;
#(
   parameter int unsigned LEN_W   = 16,
   parameter int unsigned EMPTY_W = 6
) (
   input  logic [LEN_W-1:0]   len_i,
   output logic [LEN_W-1:0]   eff_len_o,
   output logic [LEN_W-1:0]   flits_o,
   output logic [EMPTY_W-1:0] empty_o
);

   logic [LEN_W:0] round_up;

   always_comb begin
      eff_len_o = (len_i == '0) ? LEN_W'(BYTES_PER_FLIT) : len_i;
      // Extra bit keeps the round-up from overflowing for lengths near 2^LEN_W.
      round_up  = {1'b0, eff_len_o} + (LEN_W+1)'(BYTES_PER_FLIT - 1);
      flits_o   = LEN_W'(round_up >> EMPTY_W);
      // Bytes short of a flit boundary: (-len) mod BYTES_PER_FLIT.
      empty_o   = '0 - eff_len_o[EMPTY_W-1:0];
   end

endmodule

// File: rtl/stream_pkt_generator.sv
// Stream packet generator: sources a burst of self-describing packets on a
// valid/ready flit interface plus one metadata beat per packet.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a burst (sampled only when idle)
//   cfg_pkt_num/len/gap : burst size, packet length (bytes), inter-packet gap
//   out_pkt_*         : flit stream (data, valid, sop, eop, empty, ready)
//   out_meta_*        : per-packet metadata (len, seq, valid, ready)
//   busy, done        : burst in progress / one-cycle completion pulse
//   sent_pkt_cnt, sent_flit_cnt : accepted eop / flit counters since reset
// Payload: data[511:480]=seq, data[479:464]=flit index, remainder FILL_BYTE.
module stream_pkt_generator
   import stream_pkt_generator_pkg::*;
#(
   parameter int unsigned DATA_W  = 512,
   parameter int unsigned EMPTY_W = 6,
   parameter int unsigned LEN_W   = 16,
   parameter int unsigned CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [CNT_W-1:0]   cfg_pkt_num,
   input  logic [LEN_W-1:0]   cfg_pkt_len,
   input  logic [7:0]         cfg_gap,
   output logic [DATA_W-1:0]  out_pkt_data,
   output logic               out_pkt_valid,
   output logic               out_pkt_sop,
   output logic               out_pkt_eop,
   output logic [EMPTY_W-1:0] out_pkt_empty,
   input  logic               out_pkt_ready,
   output logic [LEN_W-1:0]   out_meta_len,
   output logic [CNT_W-1:0]   out_meta_seq,
   output logic               out_meta_valid,
   input  logic               out_meta_ready,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   sent_pkt_cnt,
   output logic [CNT_W-1:0]   sent_flit_cnt
);

   localparam int unsigned FILL_BYTES = (DATA_W - CNT_W - LEN_W) / 8;

   gen_state_t state_q, state_d;

   // Burst configuration latched on accepted start.
   logic [CNT_W-1:0]   num_q;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   flits_q;
   logic [EMPTY_W-1:0] empty_q;
   logic [7:0]         gap_q;

   // Progress state.
   logic [CNT_W-1:0]   seq_q;
   logic [LEN_W-1:0]   flit_idx_q;
   logic [7:0]         gap_cnt_q;
   logic               sop_shown_q;
   logic               meta_pend_q;
   logic [LEN_W-1:0]   meta_len_q;
   logic [CNT_W-1:0]   meta_seq_q;
   logic               busy_q;
   logic               done_q;
   logic [CNT_W-1:0]   pkt_cnt_q;
   logic [CNT_W-1:0]   flit_cnt_q;

   logic [LEN_W-1:0]   calc_len;
   logic [LEN_W-1:0]   calc_flits;
   logic [EMPTY_W-1:0] calc_empty;

   logic start_acc;
   logic pkt_valid;
   logic sop_first;
   logic is_eop;
   logic flit_acc;
   logic eop_acc;
   logic last_pkt;
   logic gap_end;
   logic meta_acc;

   stream_pkt_generator_len_calc #(
      .LEN_W   (LEN_W),
      .EMPTY_W (EMPTY_W)
   ) u_len_calc (
      .len_i     (cfg_pkt_len),
      .eff_len_o (calc_len),
      .flits_o   (calc_flits),
      .empty_o   (calc_empty)
   );

   always_comb begin
      start_acc = (state_q == ST_IDLE) && start;
      is_eop    = (flit_idx_q == flits_q - LEN_W'(1));
      flit_acc  = pkt_valid && out_pkt_ready;
      eop_acc   = flit_acc && is_eop;
      last_pkt  = (seq_q == num_q - CNT_W'(1));
      gap_end   = (gap_cnt_q == gap_q - 8'd1);
      meta_acc  = out_meta_valid && out_meta_ready;
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = (cfg_pkt_num == '0) ? ST_DONE : ST_SEND;
         ST_SEND: begin
            if (eop_acc) begin
               if (last_pkt)            state_d = ST_DONE;
               else if (gap_q != 8'd0)  state_d = ST_GAP;
            end
         end
         ST_GAP:  if (gap_end) state_d = ST_SEND;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      // A packet's first flit waits for the previous packet's metadata to be
      // taken; once shown, sop_shown_q keeps it valid until accepted.
      pkt_valid = (state_q == ST_SEND) &&
                  ((flit_idx_q != '0) || sop_shown_q || !meta_pend_q);
      sop_first = (state_q == ST_SEND) && (flit_idx_q == '0) &&
                  !sop_shown_q && !meta_pend_q;

      out_pkt_valid = pkt_valid;
      out_pkt_sop   = pkt_valid && (flit_idx_q == '0);
      out_pkt_eop   = pkt_valid && is_eop;
      out_pkt_empty = (pkt_valid && is_eop) ? empty_q : '0;
      out_pkt_data  = pkt_valid ? {seq_q, flit_idx_q, {FILL_BYTES{FILL_BYTE}}} : '0;

      // Metadata that outlives its packet is served from its own snapshot so
      // the next packet's seq/len (or a new burst's cfg) cannot disturb it.
      out_meta_valid = meta_pend_q || sop_first;
      out_meta_len   = meta_pend_q ? meta_len_q : len_q;
      out_meta_seq   = meta_pend_q ? meta_seq_q : seq_q;

      busy          = busy_q;
      done          = done_q;
      sent_pkt_cnt  = pkt_cnt_q;
      sent_flit_cnt = flit_cnt_q;
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         num_q       <= '0;
         len_q       <= '0;
         flits_q     <= '0;
         empty_q     <= '0;
         gap_q       <= '0;
         seq_q       <= '0;
         flit_idx_q  <= '0;
         gap_cnt_q   <= '0;
         sop_shown_q <= 1'b0;
         meta_pend_q <= 1'b0;
         meta_len_q  <= '0;
         meta_seq_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pkt_cnt_q   <= '0;
         flit_cnt_q  <= '0;
      end else begin
         done_q <= (state_q == ST_DONE);
         if (state_q == ST_DONE) busy_q <= 1'b0;

         if (start_acc) begin
            num_q      <= cfg_pkt_num;
            len_q      <= calc_len;
            flits_q    <= calc_flits;
            empty_q    <= calc_empty;
            gap_q      <= cfg_gap;
            seq_q      <= '0;
            flit_idx_q <= '0;
            busy_q     <= 1'b1;
         end

         if (flit_acc) begin
            flit_cnt_q <= flit_cnt_q + CNT_W'(1);
            if (is_eop) begin
               flit_idx_q <= '0;
               pkt_cnt_q  <= pkt_cnt_q + CNT_W'(1);
               if (!last_pkt) seq_q <= seq_q + CNT_W'(1);
            end else begin
               flit_idx_q <= flit_idx_q + LEN_W'(1);
            end
         end

         gap_cnt_q <= (state_q == ST_GAP) ? gap_cnt_q + 8'd1 : 8'd0;

         if (flit_acc)
            sop_shown_q <= 1'b0;
         else if (pkt_valid && (flit_idx_q == '0))
            sop_shown_q <= 1'b1;

         if (meta_acc)
            meta_pend_q <= 1'b0;
         else if (sop_first)
            meta_pend_q <= 1'b1;

         if (sop_first) begin
            meta_len_q <= len_q;
            meta_seq_q <= seq_q;
         end
      end
   end

endmodule

// File: tb/tb_stream_pkt_generator.sv
// Scoreboard bench for stream_pkt_generator: directed bursts push expected
// flits/metadata; a negedge monitor pops and compares on each handshake.
module tb_stream_pkt_generator;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [31:0]  cfg_pkt_num;
   logic [15:0]  cfg_pkt_len;
   logic [7:0]   cfg_gap;
   logic [511:0] out_pkt_data;
   logic         out_pkt_valid, out_pkt_sop, out_pkt_eop;
   logic [5:0]   out_pkt_empty;
   logic         out_pkt_ready;
   logic [15:0]  out_meta_len;
   logic [31:0]  out_meta_seq;
   logic         out_meta_valid, out_meta_ready;
   logic         busy, done;
   logic [31:0]  sent_pkt_cnt, sent_flit_cnt;

   always #5 clk = ~clk;

   stream_pkt_generator #(
      .DATA_W (512), .EMPTY_W (6), .LEN_W (16), .CNT_W (32)
   ) dut (
      .clk (clk), .rst (rst), .start (start),
      .cfg_pkt_num (cfg_pkt_num), .cfg_pkt_len (cfg_pkt_len), .cfg_gap (cfg_gap),
      .out_pkt_data (out_pkt_data), .out_pkt_valid (out_pkt_valid),
      .out_pkt_sop (out_pkt_sop), .out_pkt_eop (out_pkt_eop),
      .out_pkt_empty (out_pkt_empty), .out_pkt_ready (out_pkt_ready),
      .out_meta_len (out_meta_len), .out_meta_seq (out_meta_seq),
      .out_meta_valid (out_meta_valid), .out_meta_ready (out_meta_ready),
      .busy (busy), .done (done),
      .sent_pkt_cnt (sent_pkt_cnt), .sent_flit_cnt (sent_flit_cnt)
   );

   typedef struct {
      logic [511:0] data;
      logic [7:0]   ctl;   // {sop, eop, empty}
   } flit_t;

   typedef struct {
      logic [15:0] len;
      logic [31:0] seq;
   } meta_t;

   flit_t exp_flit[$];
   meta_t exp_meta[$];
   int    n_vec = 0;
   int    n_err = 0;
   bit    rand_en = 1'b0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] mk_data(input int unsigned seq, input int unsigned idx);
      logic [511:0] d;
      d = '0;
      for (int b = 0; b < 58; b++) d[b*8 +: 8] = 8'h5A;
      d[479:464] = idx[15:0];
      d[511:480] = seq;
      return d;
   endfunction

   // nflits and last_empty are supplied per test as hand-computed constants.
   task automatic push_burst(input int unsigned num, input int unsigned len,
                             input int unsigned nflits, input int unsigned last_empty);
      flit_t f;
      meta_t m;
      for (int unsigned s = 0; s < num; s++) begin
         for (int unsigned i = 0; i < nflits; i++) begin
            f.data = mk_data(s, i);
            f.ctl  = {(i == 0), (i == nflits - 1), (i == nflits - 1) ? last_empty[5:0] : 6'd0};
            exp_flit.push_back(f);
         end
         m.len = len[15:0];
         m.seq = s;
         exp_meta.push_back(m);
      end
   endtask

   // ---------------- Monitor ----------------
   logic  stall_prev = 1'b0;
   logic  mstall_prev = 1'b0;
   flit_t held;
   meta_t mheld;

   always @(negedge clk) begin
      flit_t e;
      meta_t em;
      if (rst) begin
         stall_prev  = 1'b0;
         mstall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("hold_valid", out_pkt_valid, 1);
            chk("hold_data", out_pkt_data, held.data);
            chk("hold_ctl", {out_pkt_sop, out_pkt_eop, out_pkt_empty}, held.ctl);
         end
         if (mstall_prev) begin
            chk("meta_hold", {out_meta_valid, out_meta_len, out_meta_seq},
                {1'b1, mheld.len, mheld.seq});
         end
         if (out_pkt_valid && out_pkt_ready) begin
            if (exp_flit.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL flit_unexpected: got data %0h expected no flit", out_pkt_data);
            end else begin
               e = exp_flit.pop_front();
               chk("flit_data", out_pkt_data, e.data);
               chk("flit_ctl", {out_pkt_sop, out_pkt_eop, out_pkt_empty}, e.ctl);
            end
         end
         if (out_meta_valid && out_meta_ready) begin
            if (exp_meta.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL meta_unexpected: got seq %0d expected no meta", out_meta_seq);
            end else begin
               em = exp_meta.pop_front();
               chk("meta_len", out_meta_len, em.len);
               chk("meta_seq", out_meta_seq, em.seq);
            end
         end
         stall_prev  = out_pkt_valid && !out_pkt_ready;
         held.data   = out_pkt_data;
         held.ctl    = {out_pkt_sop, out_pkt_eop, out_pkt_empty};
         mstall_prev = out_meta_valid && !out_meta_ready;
         mheld.len   = out_meta_len;
         mheld.seq   = out_meta_seq;
      end
   end

   // Random backpressure, driven just after each rising edge.
   always @(posedge clk) begin
      if (rand_en) begin
         #1;
         out_pkt_ready  = 1'($urandom_range(0, 1));
         out_meta_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- Helpers ----------------
   task automatic start_burst(input int unsigned num, input int unsigned len, input int unsigned gap);
      cfg_pkt_num = num;
      cfg_pkt_len = len[15:0];
      cfg_gap     = gap[7:0];
      start       = 1'b1;
      @(posedge clk); #1;
      start       = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget, output int cyc);
      bit seen;
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (done) seen = 1'b1;
      end
      chk(name, seen, 1);
   endtask

   // ---------------- Stimulus ----------------
   initial begin
      int   cyc;
      int   base_p, base_f;
      int   zeros, gaps_seen;
      bit   done_seen;

      rst = 1'b1; start = 1'b0;
      cfg_pkt_num = '0; cfg_pkt_len = '0; cfg_gap = '0;
      out_pkt_ready = 1'b1; out_meta_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_valids", {out_pkt_valid, out_meta_valid, busy, done}, 0);
      chk("rst_counters", {sent_pkt_cnt, sent_flit_cnt}, 0);
      chk("rst_data", out_pkt_data, 0);

      // 1 packet, 64 bytes: single flit sop=eop, empty 0, sop one cycle after start
      @(posedge clk); #1;
      push_burst(1, 64, 1, 0);
      start_burst(1, 64, 0);
      @(negedge clk);
      chk("t1_latency_sop_eop", {out_pkt_valid, out_pkt_sop, out_pkt_eop}, 3'b111);
      chk("t1_meta_valid", out_meta_valid, 1);
      wait_done("t1_done", 20, cyc);
      chk("t1_pkt_cnt", sent_pkt_cnt, 1);
      chk("t1_flit_cnt", sent_flit_cnt, 1);
      chk("t1_sb_empty", exp_flit.size() + exp_meta.size(), 0);

      // 2 packets of 65 bytes: 2 flits each, empty 63, back-to-back
      @(posedge clk); #1;
      base_p = sent_pkt_cnt; base_f = sent_flit_cnt;
      push_burst(2, 65, 2, 63);
      start_burst(2, 65, 0);
      wait_done("t2_done", 40, cyc);
      chk("t2_b2b_cycles", cyc, 6);
      chk("t2_pkt_delta", sent_pkt_cnt - base_p, 2);
      chk("t2_flit_delta", sent_flit_cnt - base_f, 4);
      chk("t2_sb_empty", exp_flit.size() + exp_meta.size(), 0);

      // 100 packets of 200 bytes (4 flits, empty 56) under random backpressure
      @(posedge clk); #1;
      base_p = sent_pkt_cnt; base_f = sent_flit_cnt;
      push_burst(100, 200, 4, 56);
      rand_en = 1'b1;
      start_burst(100, 200, 0);
      wait_done("t3_done", 4000, cyc);
      rand_en = 1'b0;
      @(posedge clk); #2;
      out_pkt_ready = 1'b1; out_meta_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t3_pkt_delta", sent_pkt_cnt - base_p, 100);
      chk("t3_flit_delta", sent_flit_cnt - base_f, 400);
      chk("t3_sb_empty", exp_flit.size() + exp_meta.size(), 0);

      // 3 packets, gap 3; a start pulse mid-burst must be ignored
      @(posedge clk); #1;
      base_p = sent_pkt_cnt; base_f = sent_flit_cnt;
      push_burst(3, 64, 1, 0);
      start_burst(3, 64, 3);
      zeros = -1; gaps_seen = 0; done_seen = 1'b0;
      for (int i = 0; i < 60 && !done_seen; i++) begin
         @(negedge clk);
         if (out_pkt_valid && out_pkt_sop && zeros >= 0) begin
            chk("t4_gap_cycles", zeros, 3);
            gaps_seen++;
            zeros = -1;
         end
         if (out_pkt_valid && out_pkt_eop) zeros = 0;
         else if (!out_pkt_valid && zeros >= 0) zeros++;
         if (done) done_seen = 1'b1;
         if (i == 4) begin
            cfg_pkt_num = 10; cfg_gap = 0; start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk("t4_done", done_seen, 1);
      chk("t4_gaps_seen", gaps_seen, 2);
      chk("t4_pkt_delta", sent_pkt_cnt - base_p, 3);
      repeat (4) @(negedge clk);
      chk("t4_idle_after", {out_pkt_valid, busy}, 0);
      chk("t4_flit_delta", sent_flit_cnt - base_f, 3);
      chk("t4_sb_empty", exp_flit.size() + exp_meta.size(), 0);

      // Zero packets: no flits, done two cycles after start
      @(posedge clk); #1;
      base_p = sent_pkt_cnt;
      cfg_pkt_num = 0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("t5_t1_state", {out_pkt_valid, done, busy}, 3'b001);
      @(negedge clk);
      chk("t5_t2_state", {out_pkt_valid, done, busy}, 3'b010);
      chk("t5_pkt_cnt", sent_pkt_cnt - base_p, 0);

      // Reset while flit 2 of 4 is presented
      @(posedge clk); #1;
      push_burst(1, 256, 4, 0);
      start_burst(1, 256, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_flit.delete();
      exp_meta.delete();
      @(negedge clk);
      chk("t6_after_rst", {out_pkt_valid, out_meta_valid, busy}, 0);
      chk("t6_cnt_rst", {sent_pkt_cnt, sent_flit_cnt}, 0);
      @(posedge clk); #1;
      push_burst(1, 64, 1, 0);
      start_burst(1, 64, 0);
      @(negedge clk);
      chk("t6_restart_sop", {out_pkt_valid, out_pkt_sop, out_meta_seq}, {2'b11, 32'd0});
      wait_done("t6_done", 20, cyc);
      chk("t6_cnts", {sent_pkt_cnt, sent_flit_cnt}, {32'd1, 32'd1});
      chk("t6_sb_empty", exp_flit.size() + exp_meta.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
